// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch miss controller:
//   state_t        - controller state encoding (IDLE, FILL, RESUME)
//   LINE_WORDS_DEF - default number of 32-bit words per I-cache line
//   OFF_W          - word-offset width for the default line size
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      RESUME = 2'd2
   } state_t;

   localparam int LINE_WORDS_DEF = 4;
   localparam int OFF_W          = $clog2(LINE_WORDS_DEF);

endpackage

// File: rtl/fetch_miss_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_miss_ctrl_if
// Memory read bus between the fetch miss controller and instruction memory.
//   memReq   - read request, held until accepted        (master -> slave)
//   memAddr  - word byte-address being requested        (master -> slave)
//   memReady - memData is valid for memAddr this cycle  (slave -> master)
//   memData  - returned 32-bit word                     (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_miss_ctrl_if #(
   parameter int ADDR_W = 32
);

   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic              memReady;
   logic [31:0]       memData;

   modport master (output memReq, memAddr, input memReady, memData);
   modport slave  (input memReq, memAddr, output memReady, memData);

endinterface

// File: rtl/line_addr_gen.sv
// -----------------------------------------------------------------------------
// line_addr_gen
// Holds the line base and word-offset counter for one refill and produces the
// current memory word address plus a flag marking the last word of the line.
//   clk, rst (sync, active-high)
//   load       - capture line base / first offset from start_addr
//   start_addr - missing PC (word-aligned byte address)
//   advance    - one word accepted; step offset modulo LINE_WORDS
//   addr       - {line base, offset, 2'b00}
//   last       - the word at addr is the LINE_WORDS-th of this refill
// Macro FETCH_MISS_CWF_EN: first offset = word offset of start_addr
// (critical word first); otherwise the refill always starts at offset 0.
// -----------------------------------------------------------------------------
module line_addr_gen
   import fetch_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam int OW = $clog2(LINE_WORDS);

   logic [ADDR_W-OW-3:0] line_tag;
   logic [OW-1:0]        offset;
   logic [OW-1:0]        count;   // words accepted so far; independent of the wrap point
   logic [OW-1:0]        first_off;

`ifdef FETCH_MISS_CWF_EN
   assign first_off = start_addr[OW+1:2];
   logic  unused_byte_bits;
   assign unused_byte_bits = ^start_addr[1:0];
`else
   assign first_off = '0;
   logic  unused_low_bits;
   assign unused_low_bits = ^start_addr[OW+1:0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_tag <= '0;
         offset   <= '0;
         count    <= '0;
      end else if (load) begin
         line_tag <= start_addr[ADDR_W-1:OW+2];
         offset   <= first_off;
         count    <= '0;
      end else if (advance) begin
         // LINE_WORDS is a power of two, so natural overflow is the wrap.
         offset   <= offset + 1'b1;
         count    <= count + 1'b1;
      end
   end

   assign addr = {line_tag, offset, 2'b00};
   assign last = (count == OW'(LINE_WORDS - 1));

endmodule

// File: rtl/fetch_miss_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_miss_ctrl
// Instruction-fetch miss controller: on an I-cache miss it stalls fetch,
// refills the whole line from memory, then releases fetch one cycle later.
// Branch redirects arriving while stalled are deferred and replayed as a
// one-cycle redirect pulse once fetch resumes.
//   Clk, Rst (sync, active-high)
//   pcValid, pcIn, hit      - fetch stage PC and cache lookup result
//   PCSrc, branchTarget     - redirect request from execute
//   mem (master)            - memory read bus (memReq/memAddr/memReady/memData)
//   fillEn/fillAddr/fillData- cache line write port
//   stall                   - freeze PC and fetch/decode latch
//   redirect, redirectPC    - deferred redirect pulse and target
//   missCount               - saturating count of serviced misses
// Macro FETCH_MISS_CWF_EN enables critical-word-first refill order.
// -----------------------------------------------------------------------------
module fetch_miss_ctrl
   import fetch_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int ADDR_W     = 32
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                pcValid,
   input  logic [ADDR_W-1:0]   pcIn,
   input  logic                hit,
   input  logic                PCSrc,
   input  logic [ADDR_W-1:0]   branchTarget,
   fetch_miss_ctrl_if.master   mem,
   output logic                fillEn,
   output logic [ADDR_W-1:0]   fillAddr,
   output logic [31:0]         fillData,
   output logic                stall,
   output logic                redirect,
   output logic [ADDR_W-1:0]   redirectPC,
   output logic [31:0]         missCount
);

   state_t            state, state_nxt;
   logic              start_miss;
   logic              accept;
   logic              last;
   logic              pending;
   logic [ADDR_W-1:0] word_addr;

   line_addr_gen #(
      .LINE_WORDS (LINE_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_addr_gen (
      .clk        (Clk),
      .rst        (Rst),
      .load       (start_miss),
      .start_addr (pcIn),
      .advance    (accept),
      .addr       (word_addr),
      .last       (last)
   );

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      start_miss = 1'b0;
      accept     = 1'b0;
      stall      = 1'b0;
      redirect   = 1'b0;
      mem.memReq = 1'b0;
      case (state)
         IDLE: begin
            // A replayed redirect owns this cycle; the PC being fetched is
            // about to be replaced, so a miss on it is not worth servicing.
            // A miss alongside PCSrc is wrong-path and is dropped too.
            if (pending) begin
               redirect = 1'b1;
            end else if (pcValid && !hit && !PCSrc) begin
               start_miss = 1'b1;
               stall      = 1'b1;
               state_nxt  = FILL;
            end
         end
         FILL: begin
            stall      = 1'b1;
            mem.memReq = 1'b1;
            if (mem.memReady) begin
               accept = 1'b1;
               if (last) state_nxt = RESUME;
            end
         end
         RESUME: begin
            stall     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem.memAddr = word_addr;
   assign fillEn      = accept;
   assign fillAddr    = word_addr;
   assign fillData    = accept ? mem.memData : 32'd0;

   // Deferred redirect: the latest PCSrc seen while stalled wins.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pending    <= 1'b0;
         redirectPC <= '0;
      end else if ((state == FILL || state == RESUME) && PCSrc) begin
         pending    <= 1'b1;
         redirectPC <= branchTarget;
      end else if (redirect) begin
         pending    <= 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst)                                missCount <= '0;
      else if (start_miss && missCount != '1) missCount <= missCount + 32'd1;
   end

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_miss_ctrl
// Directed self-checking bench for fetch_miss_ctrl (LINE_WORDS=4, ADDR_W=32).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge where state updates.
// -----------------------------------------------------------------------------
module tb_fetch_miss_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        pcValid;
   logic [31:0] pcIn;
   logic        hit;
   logic        PCSrc;
   logic [31:0] branchTarget;
   logic        fillEn;
   logic [31:0] fillAddr;
   logic [31:0] fillData;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPC;
   logic [31:0] missCount;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_miss_ctrl_if #(.ADDR_W(32)) mem_bus ();

   fetch_miss_ctrl #(
      .LINE_WORDS (4),
      .ADDR_W     (32)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .pcValid      (pcValid),
      .pcIn         (pcIn),
      .hit          (hit),
      .PCSrc        (PCSrc),
      .branchTarget (branchTarget),
      .mem          (mem_bus),
      .fillEn       (fillEn),
      .fillAddr     (fillAddr),
      .fillData     (fillData),
      .stall        (stall),
      .redirect     (redirect),
      .redirectPC   (redirectPC),
      .missCount    (missCount)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One cycle of stimulus; returns 1 time unit after the inputs change.
   task automatic drive(input logic rst, input logic pv, input logic [31:0] pc,
                        input logic h, input logic ps, input logic [31:0] bt,
                        input logic mr, input logic [31:0] md);
      @(negedge Clk);
      Rst              = rst;
      pcValid          = pv;
      pcIn             = pc;
      hit              = h;
      PCSrc            = ps;
      branchTarget     = bt;
      mem_bus.memReady = mr;
      mem_bus.memData  = md;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_checks++;
      if ({mem_bus.memReq, fillEn, stall, redirect} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: {memReq,fillEn,stall,redirect} got %b expected 0000",
                  {mem_bus.memReq, fillEn, stall, redirect});
      end
      n_checks++;
      if (missCount !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_missCount: got %h expected 0", missCount);
      end
      n_checks++;
      if ({redirectPC, mem_bus.memAddr, fillAddr, fillData} !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_addrs: redirectPC %h memAddr %h fillAddr %h fillData %h expected all 0",
                  redirectPC, mem_bus.memAddr, fillAddr, fillData);
      end
   endtask

   // Miss at pc with memReady every cycle; hit only low on the first cycle.
   task automatic run_fast_miss(input string name, input logic [31:0] pc,
                                input logic [31:0] exp0, input logic [31:0] exp1,
                                input logic [31:0] exp2, input logic [31:0] exp3,
                                input logic [31:0] exp_count);
      logic [31:0] addrs[$];
      logic [31:0] exp_addr[4];
      logic [31:0] md;
      int          stalls;
      exp_addr = '{exp0, exp1, exp2, exp3};
      stalls   = 0;
      for (int c = 0; c < 12; c++) begin
         md = 32'hA000_0000 + 32'(c);
         drive(1'b0, 1'b1, pc, (c == 0) ? 1'b0 : 1'b1, 1'b0, 32'h0, 1'b1, md);
         if (c == 0) begin
            n_checks++;
            if (stall !== 1'b1 || mem_bus.memReq !== 1'b0 || fillEn !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_first_cycle: stall %b memReq %b fillEn %b expected 1 0 0",
                        name, stall, mem_bus.memReq, fillEn);
            end
         end
         if (stall === 1'b1) stalls++;
         if (fillEn === 1'b1) begin
            addrs.push_back(fillAddr);
            n_checks++;
            if (fillData !== md) begin
               n_fail++;
               $display("FAIL %s_fillData: got %h expected %h", name, fillData, md);
            end
         end
      end
      n_checks++;
      if (addrs.size() != 4) begin
         n_fail++;
         $display("FAIL %s_fill_count: got %0d expected 4", name, addrs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (addrs[i] !== exp_addr[i]) begin
               n_fail++;
               $display("FAIL %s_fillAddr[%0d]: got %h expected %h", name, i, addrs[i], exp_addr[i]);
            end
         end
      end
      n_checks++;
      if (stalls != 6) begin
         n_fail++;
         $display("FAIL %s_stall_cycles: got %0d expected 6", name, stalls);
      end
      n_checks++;
      if (missCount !== exp_count) begin
         n_fail++;
         $display("FAIL %s_missCount: got %h expected %h", name, missCount, exp_count);
      end
   endtask

   task automatic test_basic_miss();
      run_fast_miss("basic", 32'h40, 32'h40, 32'h44, 32'h48, 32'h4C, 32'd1);
   endtask

   task automatic test_cwf_order();
`ifdef FETCH_MISS_CWF_EN
      run_fast_miss("cwf", 32'h48, 32'h48, 32'h4C, 32'h40, 32'h44, 32'd2);
`else
      run_fast_miss("cwf", 32'h48, 32'h40, 32'h44, 32'h48, 32'h4C, 32'd2);
`endif
   endtask

   task automatic test_slow_mem();
      logic [31:0] addrs[$];
      logic        prev_req;
      logic        prev_acc;
      logic [31:0] prev_addr;
      logic        mr;
      prev_req  = 1'b0;
      prev_acc  = 1'b0;
      prev_addr = 32'h0;
      for (int c = 0; c < 20; c++) begin
         mr = ((c % 3) == 2);
         drive(1'b0, 1'b1, 32'h100, (c == 0) ? 1'b0 : 1'b1, 1'b0, 32'h0, mr, 32'hB000_0000 + 32'(c));
         if (c == 1) begin
            n_checks++;
            if (mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== 32'h100) begin
               n_fail++;
               $display("FAIL slow_first_req: memReq %b memAddr %h expected 1 00000100",
                        mem_bus.memReq, mem_bus.memAddr);
            end
         end
         if (prev_req && !prev_acc) begin
            n_checks++;
            if (mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== prev_addr) begin
               n_fail++;
               $display("FAIL slow_hold[%0d]: memReq %b memAddr %h expected 1 %h",
                        c, mem_bus.memReq, mem_bus.memAddr, prev_addr);
            end
         end
         if (fillEn === 1'b1) addrs.push_back(fillAddr);
         prev_req  = mem_bus.memReq;
         prev_acc  = mem_bus.memReq && mr;
         prev_addr = mem_bus.memAddr;
      end
      n_checks++;
      if (addrs.size() != 4) begin
         n_fail++;
         $display("FAIL slow_fill_count: got %0d expected 4", addrs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (addrs[i] !== 32'h100 + 32'(4 * i)) begin
               n_fail++;
               $display("FAIL slow_fillAddr[%0d]: got %h expected %h", i, addrs[i], 32'h100 + 32'(4 * i));
            end
         end
      end
      n_checks++;
      if (missCount !== 32'd3) begin
         n_fail++;
         $display("FAIL slow_missCount: got %h expected 3", missCount);
      end
   endtask

   task automatic test_redirect();
      int          pulses;
      logic [31:0] bt;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         bt = (c == 1) ? 32'h200 : (c == 3) ? 32'h300 : 32'h999;
         drive(1'b0, 1'b1, 32'h500, (c == 0 || c == 6) ? 1'b0 : 1'b1,
               (c == 1 || c == 3) ? 1'b1 : 1'b0, bt, 1'b1, 32'h0);
         if (redirect === 1'b1) pulses++;
         if (c == 6) begin
            n_checks++;
            if (redirect !== 1'b1 || redirectPC !== 32'h300) begin
               n_fail++;
               $display("FAIL redir_pulse: redirect %b redirectPC %h expected 1 00000300",
                        redirect, redirectPC);
            end
            n_checks++;
            if (stall !== 1'b0) begin
               n_fail++;
               $display("FAIL redir_no_miss_stall: stall got %b expected 0", stall);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (mem_bus.memReq !== 1'b0) begin
               n_fail++;
               $display("FAIL redir_no_fill: memReq got %b expected 0", mem_bus.memReq);
            end
         end
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL redir_pulse_count: got %0d expected 1", pulses);
      end
      n_checks++;
      if (missCount !== 32'd4) begin
         n_fail++;
         $display("FAIL redir_missCount: got %h expected 4", missCount);
      end
   endtask

   task automatic test_wrong_path();
      drive(1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 32'h800, 1'b1, 32'h0);
      n_checks++;
      if (stall !== 1'b0 || redirect !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_path_cycle: stall %b redirect %b expected 0 0", stall, redirect);
      end
      drive(1'b0, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      n_checks++;
      if (mem_bus.memReq !== 1'b0 || fillEn !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_path_req: memReq %b fillEn %b expected 0 0", mem_bus.memReq, fillEn);
      end
      n_checks++;
      if (missCount !== 32'd4) begin
         n_fail++;
         $display("FAIL wrong_path_missCount: got %h expected 4", missCount);
      end
   endtask

   task automatic test_reset_mid_fill();
      drive(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_checks++;
      if (mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== 32'h700) begin
         n_fail++;
         $display("FAIL rst_fill_req: memReq %b memAddr %h expected 1 00000700",
                  mem_bus.memReq, mem_bus.memAddr);
      end
      drive(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      n_checks++;
      if (mem_bus.memReq !== 1'b0 || stall !== 1'b0 || fillEn !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_fill_abandon: memReq %b stall %b fillEn %b expected 0 0 0",
                  mem_bus.memReq, stall, fillEn);
      end
      n_checks++;
      if (missCount !== 32'd0 || mem_bus.memAddr !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_fill_state: missCount %h memAddr %h expected 0 0",
                  missCount, mem_bus.memAddr);
      end
   endtask

   initial begin
      Rst              = 1'b1;
      pcValid          = 1'b0;
      pcIn             = 32'h0;
      hit              = 1'b1;
      PCSrc            = 1'b0;
      branchTarget     = 32'h0;
      mem_bus.memReady = 1'b0;
      mem_bus.memData  = 32'h0;

      test_reset();
      test_basic_miss();
      test_cwf_order();
      test_slow_mem();
      test_redirect();
      test_wrong_path();
      test_reset_mid_fill();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_miss_ctrl.md
FETCH_MISS_CTRL -- requirements
Module: fetch_miss_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per I-cache line; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_W, default 32, byte-address width of PC and memory address.
REQ-003 Clk  input  1  sole clock; all state SHALL update on posedge Clk.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 pcValid  input  1  fetch stage presents a valid PC this cycle.
REQ-006 pcIn  input  ADDR_W  current fetch PC, word-aligned.
REQ-007 hit  input  1  I-cache hit for pcIn.
REQ-008 PCSrc  input  1  branch redirect request from execute.
REQ-009 branchTarget  input  ADDR_W  redirect target, valid when PCSrc=1.
REQ-010 memReq  output  1  memory read request, held until accepted.
REQ-011 memAddr  output  ADDR_W  word address being requested.
REQ-012 memReady  input  1  memory returns memData for memAddr this cycle.
REQ-013 memData  input  32  returned word.
REQ-014 fillEn  output  1  write fillData into cache at fillAddr this cycle.
REQ-015 fillAddr  output  ADDR_W  cache write address.
REQ-016 fillData  output  32  cache write data.
REQ-017 stall  output  1  freeze PC register and fetch/decode latch.
REQ-018 redirect  output  1  one-cycle pulse: load redirectPC into PC.
REQ-019 redirectPC  output  ADDR_W  deferred branch target.
REQ-020 missCount  output  32  number of misses serviced since reset.

Function
REQ-021 States SHALL be IDLE, FILL, RESUME.
REQ-022 IDLE: pcValid=1, hit=0, PCSrc=0 -> FILL; line base = pcIn with low log2(LINE_WORDS)+2 bits cleared; stall asserted combinationally in that same cycle.
REQ-023 IDLE: PCSrc=1 with a miss in the same cycle -> stay IDLE, no refill (wrong-path miss), redirect=0 (fetch applies PCSrc directly).
REQ-024 FILL: memReq=1, memAddr = base + 4*offset; on memReady=1, fillEn=1 same cycle with fillAddr=memAddr, fillData=memData, offset advances modulo LINE_WORDS.
REQ-025 FILL -> RESUME on the cycle the LINE_WORDS-th word is accepted; exactly LINE_WORDS fillEn pulses per miss, none duplicated.
REQ-026 RESUME: stall=1 for one cycle (cache re-read now hits) -> IDLE.
REQ-027 stall SHALL be 1 in FILL and RESUME, 0 in IDLE except per REQ-022.
REQ-028 PCSrc=1 during FILL or RESUME latches branchTarget into a pending register; later PCSrc overwrites (latest wins).
REQ-029 On RESUME->IDLE with pending set: redirect=1 for one cycle in the first IDLE cycle, redirectPC = latched target, pending cleared; that cycle SHALL NOT start a new miss.
REQ-030 missCount increments by 1 on each IDLE->FILL transition; saturates at 0xFFFFFFFF.
REQ-031 memReady while memReq=0 SHALL be ignored.

Reset
REQ-032 Rst=1 at a posedge: state=IDLE, offset=0, pending cleared, missCount=0; memReq, fillEn, stall, redirect=0 from the next cycle; redirectPC, memAddr, fillAddr, fillData=0.
REQ-033 Rst mid-FILL SHALL abandon the refill; the partially filled line is left to cache invalidation on reset.

Configuration
REQ-034 FETCH_MISS_CWF_EN defined: critical-word-first; first offset = pcIn word offset, wrapping modulo LINE_WORDS.
REQ-035 FETCH_MISS_CWF_EN undefined: first offset always 0, ascending order; all other behaviour identical.

Structure
REQ-036 Package fetch_pkg SHALL hold the state encoding, LINE_WORDS default, and the offset-width constant.
REQ-037 Sub-module line_addr_gen SHALL hold offset counter and wrap logic, producing memAddr and a last-word flag.

Verification
REQ-038 Rst, pcValid=1, pcIn=0x40, hit=0, memReady=1 every cycle -> fillAddr 0x40,0x44,0x48,0x4C, stall 6 cycles, missCount=1.
REQ-039 CWF build, pcIn=0x48 miss -> fillAddr 0x48,0x4C,0x40,0x44; non-CWF build -> 0x40..0x4C ascending.
REQ-040 Miss at 0x100, memReady every 3rd cycle -> memReq/memAddr held stable between accepts, exactly 4 fillEn pulses.
REQ-041 PCSrc=1 target 0x200 during FILL, then PCSrc=1 target 0x300 -> single redirect pulse after RESUME with redirectPC=0x300.
REQ-042 Miss and PCSrc=1 same IDLE cycle -> no memReq, missCount unchanged; Rst asserted in 2nd FILL cycle -> memReq=0 next cycle, missCount=0.
